// File: rtl/token_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : token_tx_scheduler_if
// Description : RX-frame and TX-handshake bundle between the token-ring core
//               datapath (master) and the TX scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface token_tx_scheduler_if;
  logic       rx_frame_valid;
  logic [2:0] rx_type;
  logic       rx_for_me;
  logic       rx_bad;
  logic       rx_ready;
  logic       tx_req;
  logic [2:0] tx_data_select;
  logic       tx_ack;

  modport master (
    output rx_frame_valid, rx_type, rx_for_me, rx_bad, tx_ack,
    input  rx_ready, tx_req, tx_data_select
  );

  modport slave (
    input  rx_frame_valid, rx_type, rx_for_me, rx_bad, tx_ack,
    output rx_ready, tx_req, tx_data_select
  );
endinterface
`default_nettype wire

// File: rtl/token_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : token_tx_scheduler
// Description : Per-frame forward/reply/token decision and token-holding
//               send / wait-for-response / retry / pass sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module token_tx_scheduler #(
  parameter int TIMEOUT    = 256,
  parameter int MAX_RETRY  = 3,
  parameter int INIT_TOKEN = 0
) (
  input  wire                        Clk_R,
  input  wire                        Rst,
  token_tx_scheduler_if.slave        bus,
  input  wire                        pkt_pending,
  output logic                       node_deliver,
  output logic                       buf_release,
  output logic                       pkt_drop,
  output logic                       protocol_err,
  output logic [3:0]                 retry_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FWD        = 3'd1,
    REPLY_ACK  = 3'd2,
    REPLY_NACK = 3'd3,
    HOLD       = 3'd4,
    SEND       = 3'd5,
    WAIT_RESP  = 3'd6,
    PASS       = 3'd7
  } state_t;

  localparam state_t     C_RESET_STATE  = (INIT_TOKEN != 0) ? HOLD : IDLE;
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  C_MAX_RETRY    = 4'(MAX_RETRY);

  localparam logic [2:0] C_TYPE_TOKEN = 3'b111;
  localparam logic [2:0] C_TYPE_ACK   = 3'b000;
  localparam logic [2:0] C_TYPE_NACK  = 3'b011;

  state_t      r_state, w_state_nx;
  logic [15:0] r_timer, w_timer_nx;
  logic [3:0]  w_retry_nx;
  logic        w_deliver_nx, w_release_nx, w_drop_nx, w_perr_nx;
  logic        w_rx_ready, w_frame;
  logic        w_is_token, w_is_ack, w_is_nack, w_is_data;
  logic        w_timeout;

  // Frame type decode; a frame only counts when the scheduler is ready for it.
  always_comb begin
    w_is_token = (bus.rx_type == C_TYPE_TOKEN);
    w_is_ack   = (bus.rx_type == C_TYPE_ACK);
    w_is_nack  = (bus.rx_type == C_TYPE_NACK);
    w_is_data  = !(w_is_token || w_is_ack || w_is_nack);
    w_frame    = bus.rx_frame_valid && w_rx_ready;
    // >= so a frame that masks the exact timeout cycle cannot strand the wait.
    w_timeout  = (r_timer >= C_TIMEOUT_LAST);
  end

  // Moore decode of the TX mux controls and RX readiness.
  always_comb begin
    w_rx_ready         = 1'b0;
    bus.tx_req         = 1'b0;
    bus.tx_data_select = 3'd0;
    case (r_state)
      IDLE:       w_rx_ready = 1'b1;
      WAIT_RESP:  w_rx_ready = 1'b1;
      FWD:        begin bus.tx_req = 1'b1; bus.tx_data_select = 3'd1; end
      REPLY_ACK:  begin bus.tx_req = 1'b1; bus.tx_data_select = 3'd3; end
      REPLY_NACK: begin bus.tx_req = 1'b1; bus.tx_data_select = 3'd4; end
      SEND:       begin bus.tx_req = 1'b1; bus.tx_data_select = 3'd0; end
      PASS:       begin bus.tx_req = 1'b1; bus.tx_data_select = 3'd2; end
      default:    ;
    endcase
    bus.rx_ready = w_rx_ready;
  end

  // Next-state, timer, retry counter and pulse computation.
  always_comb begin
    w_state_nx   = r_state;
    w_timer_nx   = r_timer;
    w_retry_nx   = retry_cnt;
    w_deliver_nx = 1'b0;
    w_release_nx = 1'b0;
    w_drop_nx    = 1'b0;
    w_perr_nx    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_frame) begin
          if (w_is_token) begin
            w_state_nx = HOLD;
          end else if (w_is_data) begin
            if (!bus.rx_for_me) begin
              w_state_nx = FWD;
            end else if (bus.rx_bad) begin
              w_state_nx = REPLY_NACK;
            end else begin
              w_state_nx   = REPLY_ACK;
              w_deliver_nx = 1'b1;
            end
          end
          // stray ACK/NACK: consumed, stay IDLE
        end
      end
      FWD, REPLY_ACK, REPLY_NACK, PASS: begin
        if (bus.tx_ack) w_state_nx = IDLE;
      end
      HOLD: begin
        w_state_nx = pkt_pending ? SEND : PASS;
      end
      SEND: begin
        if (bus.tx_ack) begin
          w_state_nx = WAIT_RESP;
          w_timer_nx = 16'd0;
        end
      end
      WAIT_RESP: begin
        if (r_timer != 16'hFFFF) w_timer_nx = r_timer + 16'd1;
        if (w_frame && w_is_ack) begin
          w_release_nx = 1'b1;
          w_retry_nx   = 4'd0;
          w_state_nx   = PASS;
        end else if ((w_frame && w_is_nack) || (!w_frame && w_timeout)) begin
          if (retry_cnt == C_MAX_RETRY) begin
            w_release_nx = 1'b1;
            w_drop_nx    = 1'b1;
            w_retry_nx   = 4'd0;
            w_state_nx   = PASS;
          end else begin
            w_retry_nx = retry_cnt + 4'd1;
            w_state_nx = SEND;
          end
        end else if (w_frame && w_is_token) begin
          w_perr_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight frame.
  always_ff @(posedge Clk_R or posedge Rst) begin
    if (Rst) begin
      r_state      <= C_RESET_STATE;
      r_timer      <= 16'd0;
      retry_cnt    <= 4'd0;
      node_deliver <= 1'b0;
      buf_release  <= 1'b0;
      pkt_drop     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_timer      <= w_timer_nx;
      retry_cnt    <= w_retry_nx;
      node_deliver <= w_deliver_nx;
      buf_release  <= w_release_nx;
      pkt_drop     <= w_drop_nx;
      protocol_err <= w_perr_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_token_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_token_tx_scheduler
// Description : Directed self-checking bench for token_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_token_tx_scheduler;

  localparam int TB_TIMEOUT   = 12;
  localparam int TB_MAX_RETRY = 3;

  logic       clk;
  logic       rst;
  logic       pkt_pending;
  logic       node_deliver, buf_release, pkt_drop, protocol_err;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  token_tx_scheduler_if bus ();

  token_tx_scheduler #(
    .TIMEOUT   (TB_TIMEOUT),
    .MAX_RETRY (TB_MAX_RETRY),
    .INIT_TOKEN(0)
  ) dut (
    .Clk_R       (clk),
    .Rst         (rst),
    .bus         (bus),
    .pkt_pending (pkt_pending),
    .node_deliver(node_deliver),
    .buf_release (buf_release),
    .pkt_drop    (pkt_drop),
    .protocol_err(protocol_err),
    .retry_cnt   (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for a single accepting edge.
  task automatic rx(input logic [2:0] t, input logic for_me, input logic bad);
    bus.rx_frame_valid = 1'b1;
    bus.rx_type        = t;
    bus.rx_for_me      = for_me;
    bus.rx_bad         = bad;
    cyc();
    bus.rx_frame_valid = 1'b0;
  endtask

  task automatic ack();
    bus.tx_ack = 1'b1;
    cyc();
    bus.tx_ack = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    pkt_pending        = 1'b0;
    bus.rx_frame_valid = 1'b0;
    bus.rx_type        = 3'b000;
    bus.rx_for_me      = 1'b0;
    bus.rx_bad         = 1'b0;
    bus.tx_ack         = 1'b0;

    // Reset state (IDLE)
    #3;
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_sel", bus.tx_data_select, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_pulses", {node_deliver, buf_release, pkt_drop, protocol_err}, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("idle_rx_ready", bus.rx_ready, 1);

    // TOKEN with nothing to send: HOLD one cycle then PASS
    rx(3'b111, 1'b0, 1'b0);
    check("hold_rx_ready", bus.rx_ready, 0);
    check("hold_tx_req", bus.tx_req, 0);
    cyc();
    check("pass_tx_req", bus.tx_req, 1);
    check("pass_sel", bus.tx_data_select, 2);
    cyc();
    check("pass_held_sel", bus.tx_data_select, 2);
    ack();
    check("pass_done_rx_ready", bus.rx_ready, 1);
    check("pass_done_tx_req", bus.tx_req, 0);

    // Good DATA for this node: deliver + ACK reply
    rx(3'b001, 1'b1, 1'b0);
    check("ack_deliver", node_deliver, 1);
    check("ack_tx_req", bus.tx_req, 1);
    check("ack_sel", bus.tx_data_select, 3);
    cyc();
    check("ack_deliver_pulse_end", node_deliver, 0);
    check("ack_sel_held", bus.tx_data_select, 3);
    ack();
    check("ack_done_rx_ready", bus.rx_ready, 1);

    // Bad DATA for this node: NACK reply, no delivery
    rx(3'b010, 1'b1, 1'b1);
    check("nack_sel", bus.tx_data_select, 4);
    check("nack_no_deliver", node_deliver, 0);
    ack();
    check("nack_done_rx_ready", bus.rx_ready, 1);

    // DATA for another node: forward
    rx(3'b101, 1'b0, 1'b0);
    check("fwd_sel", bus.tx_data_select, 1);
    check("fwd_tx_req", bus.tx_req, 1);
    check("fwd_no_deliver", node_deliver, 0);
    ack();

    // Stray ACK / NACK and stray tx_ack in IDLE are ignored
    rx(3'b000, 1'b0, 1'b0);
    check("stray_ack_idle", {bus.rx_ready, bus.tx_req}, 2'b10);
    rx(3'b011, 1'b0, 1'b0);
    check("stray_nack_idle", {bus.rx_ready, bus.tx_req}, 2'b10);
    ack();
    check("stray_txack_idle", {bus.rx_ready, bus.tx_req}, 2'b10);

    // Token with a packet: SEND, ACK 10 cycles after tx_ack
    pkt_pending = 1'b1;
    rx(3'b111, 1'b0, 1'b0);
    cyc();
    check("send_sel", bus.tx_data_select, 0);
    check("send_tx_req", bus.tx_req, 1);
    ack();
    check("wait_rx_ready", bus.rx_ready, 1);
    check("wait_tx_req", bus.tx_req, 0);
    repeat (9) cyc();
    rx(3'b000, 1'b0, 1'b0);
    check("resp_ack_release", buf_release, 1);
    check("resp_ack_no_drop", pkt_drop, 0);
    check("resp_ack_retry", retry_cnt, 0);
    check("resp_ack_pass_sel", bus.tx_data_select, 2);
    check("resp_ack_pass_req", bus.tx_req, 1);
    cyc();
    check("release_pulse_end", buf_release, 0);
    ack();
    check("one_pkt_per_token", {bus.rx_ready, bus.tx_req}, 2'b10);

    // Four NACKs: SEND four times, then release + drop
    rx(3'b111, 1'b0, 1'b0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("retry_send_sel", bus.tx_data_select, 0);
      check("retry_send_req", bus.tx_req, 1);
      check("retry_cnt_val", retry_cnt, 16'(k));
      ack();
      rx(3'b011, 1'b0, 1'b0);
    end
    check("drop_release", buf_release, 1);
    check("drop_pulse", pkt_drop, 1);
    check("drop_retry_clr", retry_cnt, 0);
    check("drop_pass_sel", bus.tx_data_select, 2);
    ack();

    // Timeout: resend after exactly TB_TIMEOUT WAIT_RESP cycles
    rx(3'b111, 1'b0, 1'b0);
    cyc();
    ack();
    repeat (TB_TIMEOUT - 1) cyc();
    check("to_still_wait", {bus.rx_ready, bus.tx_req}, 2'b10);
    cyc();
    check("to_resend_req", bus.tx_req, 1);
    check("to_resend_sel", bus.tx_data_select, 0);
    check("to_retry", retry_cnt, 1);

    // NACK on the timeout cycle counts once
    ack();
    repeat (TB_TIMEOUT - 1) cyc();
    rx(3'b011, 1'b0, 1'b0);
    check("nack_on_to_retry", retry_cnt, 2);
    check("nack_on_to_send", bus.tx_req, 1);
    cyc();
    check("nack_on_to_retry_stable", retry_cnt, 2);

    // TOKEN while holding the token, then discarded DATA, then ACK
    ack();
    rx(3'b111, 1'b0, 1'b0);
    check("perr_pulse", protocol_err, 1);
    check("perr_state_kept", {bus.rx_ready, bus.tx_req}, 2'b10);
    check("perr_retry_kept", retry_cnt, 2);
    cyc();
    check("perr_pulse_end", protocol_err, 0);
    rx(3'b001, 1'b1, 1'b0);
    check("wait_data_discard", {bus.rx_ready, bus.tx_req, node_deliver}, 3'b100);
    rx(3'b000, 1'b0, 1'b0);
    check("late_ack_release", buf_release, 1);
    check("late_ack_retry_clr", retry_cnt, 0);
    check("late_ack_pass_sel", bus.tx_data_select, 2);
    ack();

    // Asynchronous reset in SEND
    rx(3'b111, 1'b0, 1'b0);
    cyc();
    check("pre_rst_send", bus.tx_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx_req", bus.tx_req, 0);
    check("async_rst_rx_ready", bus.rx_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("post_rst_idle", {bus.rx_ready, bus.tx_req}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/token_tx_scheduler.md
Name: token_tx_scheduler

Overview:
- Sequencing controller for the token-ring router core datapath.
- Decides per received frame whether to forward it, reply ACK/NACK, or take the token.
- While the token is held, sends the buffered node packet, waits for ACK/NACK with a timeout, retries, then passes the token on.
- Drives the core's TX mux select and TX request, and the node-buffer release/drop strobes.

Parameters:
- TIMEOUT, 256: cycles in WAIT_RESP before a missing response counts as NACK (range 2..65535).
- MAX_RETRY, 3: retransmissions after the first send before the packet is dropped (range 0..15).
- INIT_TOKEN, 0: 1 = this node leaves reset in HOLD, owning the ring's single token.

Ports:
- Clk_R  in  1  clock; all flops rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- rx_frame_valid  in  1  decoded RX frame present; sampled only when rx_ready=1.
- rx_type  in  3  frame type: 3'b111 TOKEN, 3'b000 ACK, 3'b011 NACK, any other value is DATA.
- rx_for_me  in  1  DATA address matches this node.
- rx_bad  in  1  DATA decode error.
- pkt_pending  in  1  node buffer holds an unsent packet.
- tx_ack  in  1  TX handshake accepted the presented frame; 1-cycle pulse.
- rx_ready  out  1  scheduler can accept a frame this cycle.
- tx_req  out  1  frame selected by tx_data_select is to be sent; held until tx_ack.
- tx_data_select  out  3  0 buffer, 1 forward RX data, 2 TOKEN, 3 ACK, 4 NACK.
- node_deliver  out  1  pulse: good DATA frame for this node, present it to the node.
- buf_release  out  1  pulse: node buffer may be freed.
- pkt_drop  out  1  pulse: retries exhausted.
- protocol_err  out  1  pulse: TOKEN received while already owning the token.
- retry_cnt  out  4  current retry count.

Behaviour:
- States: IDLE, FWD, REPLY_ACK, REPLY_NACK, HOLD, SEND, WAIT_RESP, PASS.
- Reset (async, immediate): state = HOLD if INIT_TOKEN else IDLE. Timer = 0, retry_cnt = 0, all pulses 0, tx_req = 0, tx_data_select = 0.
- Reset mid-operation abandons any in-flight frame. A held token is lost unless INIT_TOKEN=1.
- Moore decode of state:
  - rx_ready = 1 only in IDLE and WAIT_RESP.
  - tx_req = 1 in FWD, REPLY_*, SEND, PASS.
  - tx_data_select: FWD = 1, REPLY_ACK = 3, REPLY_NACK = 4, SEND = 0, PASS = 2; 0 elsewhere.
- Pulses are registered and asserted exactly one cycle, in the cycle after the causing edge.
- IDLE, on rx_frame_valid:
  - TOKEN -> HOLD.
  - DATA && rx_for_me && !rx_bad -> REPLY_ACK, plus node_deliver.
  - DATA && rx_for_me && rx_bad -> REPLY_NACK.
  - DATA && !rx_for_me -> FWD.
  - ACK/NACK (stray) -> consumed and discarded, stay IDLE.
- FWD, REPLY_*: hold tx_req until tx_ack -> IDLE.
- HOLD: one cycle; pkt_pending -> SEND, else -> PASS.
- SEND: tx_ack -> WAIT_RESP with timer = 0.
- WAIT_RESP: timer increments every cycle. Resolution, in priority order:
  - rx ACK -> buf_release, retry_cnt = 0, PASS.
  - rx NACK, or timer == TIMEOUT-1 with no frame: if retry_cnt == MAX_RETRY -> buf_release + pkt_drop, retry_cnt = 0, PASS; else retry_cnt+1 -> SEND.
  - rx TOKEN -> protocol_err, frame discarded, stay.
  - Other DATA -> discarded, stay. The timer keeps running.
  - A frame in the same cycle as the timeout takes priority over the timeout.
- PASS: tx_ack -> IDLE. pkt_pending is not re-examined; one packet per token visit.
- tx_ack outside a tx_req state is ignored.
- Timer is 16 bits and saturates; it is never compared beyond TIMEOUT-1.

Test Plan:
- INIT_TOKEN=0, reset, rx TOKEN with pkt_pending=0 -> HOLD 1 cycle, then tx_req=1 with select=2. tx_ack -> IDLE, rx_ready=1.
- rx DATA rx_for_me=1 rx_bad=0 -> node_deliver pulse, select=3 until tx_ack. With rx_bad=1 -> select=4, no node_deliver. With rx_for_me=0 -> select=1.
- TOKEN with pkt_pending=1 -> select=0. tx_ack, then ACK 10 cycles later -> buf_release, retry_cnt=0, select=2.
- MAX_RETRY=3: four NACKs -> SEND entered 4 times, retry_cnt reaches 3, then buf_release + pkt_drop together and PASS.
- TIMEOUT=8: no response -> resend after exactly 8 WAIT_RESP cycles. NACK arriving on timeout cycle 7 -> one retry only, not two.
- TOKEN during WAIT_RESP -> protocol_err, state unchanged. Rst asserted in SEND -> tx_req=0 the same cycle (async), IDLE after release.
